// File: rtl/iic_arbiter_if.sv
// Bundle of client-side and iic_ctrl-side signals for the two-client I2C arbiter.
// Element N of every c_* vector belongs to client cN.
interface iic_arbiter_if;
    logic [1:0]       c_req;
    logic [1:0]       c_rw;
    logic [1:0][7:0]  c_id;
    logic [1:0][15:0] c_addr;
    logic [1:0]       c_mode;
    logic [1:0][5:0]  c_num;
    logic [1:0][7:0]  c_wdata;
    logic [1:0]       c_grant;
    logic [1:0]       c_wnext;
    logic [1:0]       c_rvalid;
    logic [1:0][7:0]  c_rdata;
    logic [1:0]       c_done;
    logic [1:0]       c_err;

    logic             m_w_req;
    logic             m_r_req;
    logic [7:0]       m_device_id;
    logic [15:0]      m_reg_addr;
    logic             m_addr_mode;
    logic [5:0]       m_w_num;
    logic [5:0]       m_r_num;
    logic [7:0]       m_wr_data;
    logic [7:0]       m_rd_data;
    logic             m_w_valid;
    logic             m_r_valid;
    logic             m_wr_done;
    logic             m_ack;
    logic             busy;

    modport slave (
        input  c_req, c_rw, c_id, c_addr, c_mode, c_num, c_wdata,
        input  m_rd_data, m_w_valid, m_r_valid, m_wr_done, m_ack,
        output c_grant, c_wnext, c_rvalid, c_rdata, c_done, c_err,
        output m_w_req, m_r_req, m_device_id, m_reg_addr, m_addr_mode,
        output m_w_num, m_r_num, m_wr_data, busy
    );

    modport master (
        output c_req, c_rw, c_id, c_addr, c_mode, c_num, c_wdata,
        output m_rd_data, m_w_valid, m_r_valid, m_wr_done, m_ack,
        input  c_grant, c_wnext, c_rvalid, c_rdata, c_done, c_err,
        input  m_w_req, m_r_req, m_device_id, m_reg_addr, m_addr_mode,
        input  m_w_num, m_r_num, m_wr_data, busy
    );
endinterface

// File: rtl/iic_arbiter.sv
// Round-robin arbiter and sequencer letting two clients share one iic_ctrl master,
// with an EEPROM write-cycle hold-off after every acknowledged write.
module iic_arbiter #(
    parameter int WR_WAIT_CYC = 250000,
    parameter int CNT_W       = 18
) (
    input  logic          i_clk,
    input  logic          i_rst,
    iic_arbiter_if.slave  bus
);
    // state    | meaning
    // IDLE     | arbitrate pending requests
    // ISSUE    | one-cycle grant and m_*_req pulse
    // WAIT     | transaction running, handshakes routed to owner
    // WR_WAIT  | EEPROM internal write time after an acked write
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_WR_WAIT} state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(WR_WAIT_CYC - 1);

    state_t           r_state, w_state_nx;
    logic             r_last, w_last_nx;
    logic             r_owner, w_owner_nx;
    logic             r_rw, w_rw_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_grant, w_grant_nx;
    logic [1:0]       r_done, w_done_nx;
    logic [1:0]       r_err, w_err_nx;
    logic             r_w_req, w_w_req_nx;
    logic             r_r_req, w_r_req_nx;
    logic [7:0]       r_id, w_id_nx;
    logic [15:0]      r_addr, w_addr_nx;
    logic             r_mode, w_mode_nx;
    logic [5:0]       r_num, w_num_nx;
    logic             w_win;
    logic             w_wait;
    logic [1:0]       w_own_oh;

    // On a tie the client not granted last time wins.
    assign w_win    = (bus.c_req == 2'b11) ? ~r_last : bus.c_req[1];
    assign w_wait   = (r_state == ST_WAIT);
    assign w_own_oh = r_owner ? 2'b10 : 2'b01;

    always_comb begin
        w_state_nx = r_state;
        w_last_nx  = r_last;
        w_owner_nx = r_owner;
        w_rw_nx    = r_rw;
        w_cnt_nx   = r_cnt;
        w_grant_nx = 2'b00;
        w_done_nx  = 2'b00;
        w_err_nx   = 2'b00;
        w_w_req_nx = 1'b0;
        w_r_req_nx = 1'b0;
        w_id_nx    = r_id;
        w_addr_nx  = r_addr;
        w_mode_nx  = r_mode;
        w_num_nx   = r_num;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.c_req != 2'b00) begin
                    w_owner_nx = w_win;
                    w_rw_nx    = bus.c_rw[w_win];
                    w_id_nx    = bus.c_id[w_win];
                    w_addr_nx  = bus.c_addr[w_win];
                    w_mode_nx  = bus.c_mode[w_win];
                    w_num_nx   = bus.c_num[w_win];
                    w_grant_nx = w_win ? 2'b10 : 2'b01;
                    w_w_req_nx = ~bus.c_rw[w_win] & (bus.c_num[w_win] != 6'd0);
                    w_r_req_nx = bus.c_rw[w_win] & (bus.c_num[w_win] != 6'd0);
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_last_nx = r_owner;
                if (r_num == 6'd0) begin
                    w_done_nx  = w_own_oh;
                    w_err_nx   = w_own_oh;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.m_wr_done) begin
                    w_done_nx = w_own_oh;
                    w_err_nx  = bus.m_ack ? w_own_oh : 2'b00;
                    if (!r_rw && !bus.m_ack) begin
                        w_cnt_nx   = '0;
                        w_state_nx = ST_WR_WAIT;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_rw    <= 1'b0;
            r_cnt   <= '0;
            r_grant <= 2'b00;
            r_done  <= 2'b00;
            r_err   <= 2'b00;
            r_w_req <= 1'b0;
            r_r_req <= 1'b0;
            r_id    <= 8'd0;
            r_addr  <= 16'd0;
            r_mode  <= 1'b0;
            r_num   <= 6'd0;
        end else begin
            r_state <= w_state_nx;
            r_last  <= w_last_nx;
            r_owner <= w_owner_nx;
            r_rw    <= w_rw_nx;
            r_cnt   <= w_cnt_nx;
            r_grant <= w_grant_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_w_req <= w_w_req_nx;
            r_r_req <= w_r_req_nx;
            r_id    <= w_id_nx;
            r_addr  <= w_addr_nx;
            r_mode  <= w_mode_nx;
            r_num   <= w_num_nx;
        end
    end

    assign bus.c_grant     = r_grant;
    assign bus.c_done      = r_done;
    assign bus.c_err       = r_err;
    assign bus.m_w_req     = r_w_req;
    assign bus.m_r_req     = r_r_req;
    assign bus.m_device_id = r_id;
    assign bus.m_reg_addr  = r_addr;
    assign bus.m_addr_mode = r_mode;
    assign bus.m_w_num     = r_num;
    assign bus.m_r_num     = r_num;
    assign bus.busy        = (r_state != ST_IDLE);

    // Per-byte handshakes reach only the owner, and only while a transfer runs.
    assign bus.m_wr_data = w_wait ? bus.c_wdata[r_owner] : 8'd0;
    assign bus.c_wnext   = (w_wait && bus.m_w_valid) ? w_own_oh : 2'b00;
    assign bus.c_rvalid  = (w_wait && bus.m_r_valid) ? w_own_oh : 2'b00;
    assign bus.c_rdata   = {bus.m_rd_data, bus.m_rd_data};
endmodule

// File: tb/tb_iic_arbiter.sv
// Bench for iic_arbiter: directed test-plan scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a timestamp-based reference model.
module tb_iic_arbiter;
    localparam int N  = 6;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    iic_arbiter_if bus();

    iic_arbiter #(.WR_WAIT_CYC(N), .CNT_W(CW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: tracks the outstanding transaction and the first cycle the
    // arbiter is idle again, instead of an explicit state machine.
    int          k = 0;
    bit          in_txn;
    int          issue_k;
    int          idle_from;
    int          rej_at;
    bit          last;
    bit          owner;
    bit          own_rw;
    logic [1:0]  e_grant, e_done, e_err;
    logic        e_wreq, e_rreq;
    logic [7:0]  e_id;
    logic [15:0] e_addr;
    logic        e_mode;
    logic [5:0]  e_num;

    function automatic void model_reset();
        in_txn = 0; issue_k = 0; idle_from = -100; rej_at = -100;
        last = 1; owner = 0; own_rw = 0;
        e_grant = 0; e_done = 0; e_err = 0; e_wreq = 0; e_rreq = 0;
        e_id = 0; e_addr = 0; e_mode = 0; e_num = 0;
    endfunction

    function automatic void model_step();
        bit w;
        k++;
        e_grant = 0; e_done = 0; e_err = 0; e_wreq = 0; e_rreq = 0;
        if (rej_at == k) begin
            e_done[owner] = 1'b1;
            e_err[owner]  = 1'b1;
        end
        if (in_txn && (k - 1 > issue_k) && bus.m_wr_done) begin
            e_done[owner] = 1'b1;
            e_err[owner]  = bus.m_ack;
            in_txn = 0;
            idle_from = k + ((!own_rw && !bus.m_ack) ? N : 0);
        end else if (!in_txn && (k - 1 >= idle_from) && (bus.c_req != 2'b00)) begin
            w = (bus.c_req == 2'b11) ? !last : bus.c_req[1];
            e_grant[w] = 1'b1;
            owner = w;
            last  = w;
            e_id   = bus.c_id[w];
            e_addr = bus.c_addr[w];
            e_mode = bus.c_mode[w];
            e_num  = bus.c_num[w];
            if (e_num == 6'd0) begin
                rej_at = k + 1;
                idle_from = k + 1;
            end else begin
                in_txn  = 1;
                issue_k = k;
                own_rw  = bus.c_rw[w];
                e_wreq  = !own_rw;
                e_rreq  = own_rw;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            k++;
            model_reset();
        end else begin
            model_step();
        end
    end

    always @(posedge rst) model_reset();

    always @(negedge clk) begin
        bit         wt;
        logic [1:0] oh;
        wt = !rst && in_txn && (k > issue_k);
        oh = owner ? 2'b10 : 2'b01;
        chk("grant",   32'(bus.c_grant), 32'(e_grant));
        chk("done",    32'(bus.c_done),  32'(e_done));
        chk("err",     32'(bus.c_err),   32'(e_err));
        chk("w_req",   32'(bus.m_w_req), 32'(e_wreq));
        chk("r_req",   32'(bus.m_r_req), 32'(e_rreq));
        chk("busy",    32'(bus.busy),    32'(in_txn || (k < idle_from)));
        chk("dev_id",  32'(bus.m_device_id), 32'(e_id));
        chk("addr",    32'(bus.m_reg_addr),  32'(e_addr));
        chk("mode",    32'(bus.m_addr_mode), 32'(e_mode));
        chk("w_num",   32'(bus.m_w_num), 32'(e_num));
        chk("r_num",   32'(bus.m_r_num), 32'(e_num));
        chk("wnext",   32'(bus.c_wnext),  32'((wt && bus.m_w_valid) ? oh : 2'b00));
        chk("rvalid",  32'(bus.c_rvalid), 32'((wt && bus.m_r_valid) ? oh : 2'b00));
        chk("wr_data", 32'(bus.m_wr_data), 32'(wt ? bus.c_wdata[owner] : 8'd0));
        for (int i = 0; i < 2; i++) begin
            if (bus.c_rvalid[i]) chk("rdata", 32'(bus.c_rdata[i]), 32'(bus.m_rd_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input bit rw, input logic [7:0] id, input logic [5:0] num);
        bus.c_rw[c]   = rw;
        bus.c_id[c]   = id;
        bus.c_addr[c] = 16'h0000;
        bus.c_mode[c] = 1'b0;
        bus.c_num[c]  = num;
        bus.c_req[c]  = 1'b1;
    endtask

    task automatic wait_grant(input int c, input string name, input int exp_n);
        int n;
        n = 0;
        while (!bus.c_grant[c] && n < 40) begin
            step();
            n++;
        end
        chk(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        model_reset();
        bus.c_req = 0; bus.c_rw = 0; bus.c_id = 0; bus.c_addr = 0;
        bus.c_mode = 0; bus.c_num = 0; bus.c_wdata = 0;
        bus.m_rd_data = 0; bus.m_w_valid = 0; bus.m_r_valid = 0;
        bus.m_wr_done = 0; bus.m_ack = 0;

        repeat (3) step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wreq", 32'(bus.m_w_req), 32'd0);
        rst = 1'b0;

        // Tie from reset: c0 write of D1..D4, c1 read waiting behind it.
        set_req(0, 1'b0, 8'hA0, 6'd4);
        set_req(1, 1'b1, 8'hA1, 6'd4);
        step();
        chk("tie_c0_grant", 32'(bus.c_grant), 32'h1);
        chk("tie_w_req",    32'(bus.m_w_req), 32'h1);
        chk("tie_dev_id",   32'(bus.m_device_id), 32'hA0);
        chk("tie_w_num",    32'(bus.m_w_num), 32'd4);
        bus.c_req[0] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            step();
            bus.m_w_valid = 1'b1;
            bus.c_wdata[0] = 8'(8'hD1 + b);
            #1;
            chk("wr_byte", 32'(bus.m_wr_data), 32'(8'hD1 + b));
            chk("wr_next", 32'(bus.c_wnext), 32'h1);
        end
        step();
        bus.m_w_valid = 1'b0;
        bus.m_wr_done = 1'b1;
        step();
        bus.m_wr_done = 1'b0;
        chk("wr_done",     32'(bus.c_done), 32'h1);
        chk("wr_err",      32'(bus.c_err),  32'h0);
        chk("wr_wait_bsy", 32'(bus.busy),   32'h1);
        wait_grant(1, "wr_turnaround", N + 1);
        chk("rd_r_req", 32'(bus.m_r_req), 32'h1);
        bus.c_req[1] = 1'b0;
        set_req(0, 1'b0, 8'hA0, 6'd0);

        // Read back by c1; c0's pending zero-length request is rejected next.
        for (int b = 0; b < 4; b++) begin
            step();
            bus.m_r_valid = 1'b1;
            bus.m_rd_data = 8'(8'hD1 + b);
            #1;
            chk("rd_valid1", 32'(bus.c_rvalid), 32'h2);
            chk("rd_data1",  32'(bus.c_rdata[1]), 32'(8'hD1 + b));
        end
        step();
        bus.m_r_valid = 1'b0;
        bus.m_wr_done = 1'b1;
        step();
        bus.m_wr_done = 1'b0;
        chk("rd_done", 32'(bus.c_done), 32'h2);
        chk("rd_busy", 32'(bus.busy),   32'h0);
        wait_grant(0, "rd_turnaround", 1);
        chk("rej_noreq", 32'({bus.m_w_req, bus.m_r_req}), 32'h0);
        bus.c_req[0] = 1'b0;
        step();
        chk("rej_done", 32'(bus.c_done), 32'h1);
        chk("rej_err",  32'(bus.c_err),  32'h1);

        // NACKed write: no write wait, then a second tie goes to c1.
        set_req(0, 1'b0, 8'hA0, 6'd2);
        step();
        chk("nack_grant", 32'(bus.c_grant), 32'h1);
        bus.c_req[0] = 1'b0;
        step();
        bus.m_wr_done = 1'b1;
        bus.m_ack = 1'b1;
        step();
        bus.m_wr_done = 1'b0;
        bus.m_ack = 1'b0;
        chk("nack_err",  32'(bus.c_err),  32'h1);
        chk("nack_busy", 32'(bus.busy),   32'h0);
        set_req(0, 1'b0, 8'hA0, 6'd2);
        set_req(1, 1'b1, 8'hA1, 6'd1);
        wait_grant(1, "tie2_turnaround", 1);
        chk("tie2_c1", 32'(bus.c_grant), 32'h2);
        bus.c_req[1] = 1'b0;
        step();
        bus.m_wr_done = 1'b1;
        step();
        bus.m_wr_done = 1'b0;
        step();
        chk("c0_after_tie2", 32'(bus.c_grant), 32'h1);
        bus.c_req[0] = 1'b0;

        // Reset while c0 is in its transfer, with c1 waiting.
        set_req(1, 1'b1, 8'hA1, 6'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'h0);
        chk("rst_mid_done", 32'(bus.c_done), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("rst_c1_first", 32'(bus.c_grant), 32'h2);
        bus.c_req[1] = 1'b0;

        // Randomized traffic, including stray iic_ctrl strobes and occasional resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            bus.m_w_valid = ($urandom_range(0, 2) == 0);
            bus.m_r_valid = ($urandom_range(0, 2) == 0);
            bus.m_rd_data = 8'($urandom);
            bus.m_wr_done = ($urandom_range(0, 9) == 0);
            bus.m_ack     = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 2; i++) begin
                bus.c_wdata[i] = 8'($urandom);
                if (bus.c_req[i] && bus.c_grant[i]) begin
                    bus.c_req[i] = 1'b0;
                end else if (!bus.c_req[i] && $urandom_range(0, 5) == 0) begin
                    bus.c_rw[i]   = 1'($urandom_range(0, 1));
                    bus.c_id[i]   = 8'($urandom);
                    bus.c_addr[i] = 16'($urandom);
                    bus.c_mode[i] = 1'($urandom_range(0, 1));
                    bus.c_num[i]  = 6'($urandom_range(0, 5));
                    bus.c_req[i]  = 1'b1;
                end
            end
            if ($urandom_range(0, 699) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iic_arbiter.md
# iic_arbiter

Two-client arbiter and sequencer in front of `iic_ctrl`. It lets two independent requesters share one I2C master, for example an EEPROM parameter loader and a runtime logger. It round-robins between their transaction requests, latches the winner's command fields, and issues a single-cycle `w_req`/`r_req` to `iic_ctrl`. It routes per-byte handshakes back to the owner and enforces the EEPROM internal write-cycle time after every successful write before granting again.

## Interface
Parameters:
- WR_WAIT_CYC, 250000, idle cycles after a successful write (5 ms at 50 MHz); must be ≥1
- CNT_W, 18, width of the write-wait counter; 2^CNT_W > WR_WAIT_CYC

Ports (`cN_` denotes each of `c0_` and `c1_`):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cN_req  in  1  transaction request level
- cN_rw  in  1  0 = write, 1 = read
- cN_id  in  8  device ID
- cN_addr  in  16  register address
- cN_mode  in  1  address mode, passed to `addr_mode`
- cN_num  in  6  byte count
- cN_wdata  in  8  current write byte
- cN_grant  out  1  one-cycle pulse: request accepted, fields latched
- cN_wnext  out  1  forwarded `w_valid`: present next write byte
- cN_rvalid  out  1  forwarded `r_valid`: `cN_rdata` valid
- cN_rdata  out  8  read byte (`m_rd_data` broadcast)
- cN_done  out  1  one-cycle pulse: transaction finished
- cN_err  out  1  valid with `cN_done`: NACK, or rejected request
- m_w_req, m_r_req  out  1  to `iic_ctrl` `w_req`/`r_req`
- m_device_id  out  8  to `iic_ctrl`
- m_reg_addr  out  16  to `iic_ctrl`
- m_addr_mode  out  1  to `iic_ctrl`
- m_w_num, m_r_num  out  6  to `iic_ctrl`
- m_wr_data  out  8  to `iic_ctrl`
- m_rd_data  in  8  from `iic_ctrl`
- m_w_valid, m_r_valid  in  1  from `iic_ctrl`
- m_wr_done  in  1  from `iic_ctrl`, end of transaction
- m_ack  in  1  from `iic_ctrl`, sampled with `m_wr_done`; 1 = NACK
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, WR_WAIT.
- IDLE, with any `cN_req` high at a clock edge, moves to ISSUE:
  - owner := winner;
  - latch `rw`/`id`/`addr`/`mode`/`num` into `m_*`; `m_w_num` and `m_r_num` both get `num`.
- Arbitration is round-robin. `last` holds the previously granted client; reset value 1, so c0 wins the first tie. With one requester, that requester wins.
- ISSUE lasts one cycle:
  - `cN_grant` = 1 for the owner;
  - exactly one of `m_w_req`/`m_r_req` = 1, per `rw`;
  - `last` := owner; next state WAIT.
- `num` = 0 is rejected:
  - ISSUE pulses grant but no `m_*_req`;
  - the next cycle pulses `cN_done` with `cN_err` = 1, and the state returns to IDLE.
- In WAIT:
  - `m_wr_data` = owner's `cN_wdata`, combinational;
  - `cN_wnext` = `m_w_valid` & owner; `cN_rvalid` = `m_r_valid` & owner; the non-owner sees 0.
- When `m_wr_done` = 1 in WAIT, on the next cycle:
  - `cN_done` = 1 and `cN_err` = `m_ack` for the owner;
  - next state is WR_WAIT if the transaction was a write with `m_ack` = 0, else IDLE.
- WR_WAIT:
  - counter loads 0 on entry and increments each cycle;
  - leaves to IDLE when counter = WR_WAIT_CYC−1, i.e. exactly WR_WAIT_CYC cycles in WR_WAIT.
- Requests are never lost. A `cN_req` held during busy is served after return to IDLE. A client drops `req` after its grant or it is re-served.
- `m_w_valid`/`m_r_valid`/`m_wr_done` arriving in IDLE or WR_WAIT are ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `last` = 1, counter 0. Reset mid-transaction aborts immediately; no done pulse is produced.
- `m_*_req`, `cN_grant`, `cN_done`, `cN_err`, `busy` and `m_*` command fields are registered. `m_wr_data`, `cN_wnext`, `cN_rvalid` and `cN_rdata` are combinational.
- Request-to-master latency: `req` sampled at edge T; `m_*_req` and grant are high during cycle T+1.
- `m_wr_done` high at edge D produces `cN_done` high during D+1.
- Write turnaround: after a write done, the earliest next `m_*_req` is WR_WAIT_CYC+2 cycles later. After a read done it is 2 cycles later.
- `busy` rises with ISSUE and falls on entry to IDLE.

## Test plan
- **Single write:** c0 write, id A0, addr 0000, num 4, bytes D1–D4 → one `m_w_req` pulse; `c0_wnext` ×4 with `m_wr_data` D1..D4; `c0_done`, `c0_err` = 0; `busy` held WR_WAIT_CYC more cycles.
- **Tie:** c0 and c1 requesting in the same cycle from reset → c0 granted first, c1 granted after c0's write wait; a second tie → c1 first.
- **Read:** c1 read, num 4 at addr 0000 after the write → `c1_rvalid` ×4 with D1..D4; `c0_rvalid` stays 0; next grant 2 cycles after done.
- **NACK:** `m_ack` = 1 at `m_wr_done` on a write → `c0_err` = 1 with done, no WR_WAIT; next request is issued 2 cycles later.
- **Reject:** `num` = 0 → grant, no `m_*_req`, done+err the following cycle.
- **Reset:** `rst` asserted in WAIT → all outputs 0 immediately; after release the pending c1 request is served first (`last` = 1 rule).
